wb_data_ram: RTL and testbench
==============================

WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra cycles inserted between request acceptance and ack (0..15).
REQ-003 SHALL have ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_bus_cyc_data  in  1  bus cycle active; 0 cancels any outstanding transaction.
- wb_stb_data  in  1  request strobe.
- wb_w_r_en_data  in  1  1 = write, 0 = read.
- wb_addr_data  in  32  byte address.
- wb_wdata_data  in  32  store data, already byte-lane aligned.
- wb_sel_data  in  4  byte-lane enables {byte3..byte0}.
- wb_ack_data  out  1  one-cycle completion pulse.
- wb_stall_data  out  1  responder busy; request not accepted while high.
- wb_rdata_data  out  32  read data, valid in the ack cycle.

Function
REQ-004 SHALL accept a request in a cycle where wb_bus_cyc_data && wb_stb_data && !wb_stall_data.
REQ-005 SHALL use word index wb_addr_data[log2(DEPTH_WORDS)+1:2]; wb_addr_data[1:0] ignored.
REQ-006 SHALL treat wb_addr_data >= 4*DEPTH_WORDS as out of range: write suppressed, read returns 32'h0, ack still issued.
REQ-007 SHALL, on an accepted in-range write, update exactly the bytes whose wb_sel_data bit is 1, at the acceptance clock edge; wb_sel_data = 0 writes nothing but is acked.
REQ-008 SHALL, on an accepted read, capture the addressed word at the acceptance edge into a holding register; wb_sel_data ignored for reads (full word returned).
REQ-009 SHALL implement states IDLE, WAIT, ACK:
- IDLE: accept -> WAIT if WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1), else ACK.
- WAIT: counter decrements each cycle; at 0 -> ACK.
- ACK: wb_ack_data=1 for this cycle only; accept here -> WAIT/ACK as from IDLE (back-to-back), else -> IDLE.
REQ-010 SHALL drive wb_stall_data = 1 only in WAIT; 0 in IDLE and ACK.
REQ-011 SHALL give latency acceptance-edge to ack-cycle of 1+WAIT_CYCLES cycles; WAIT_CYCLES=0 sustains one transaction per cycle.
REQ-012 SHALL drive wb_rdata_data = captured word during ack of a read, 32'h0 during ack of a write; value held unchanged between acks.
REQ-013 SHALL, if wb_bus_cyc_data=0 in any cycle while in WAIT or ACK, return to IDLE next cycle with no (further) ack; a write already committed at acceptance is not rolled back.
REQ-014 SHALL not accept a request while wb_bus_cyc_data=0, regardless of wb_stb_data.
REQ-015 SHALL make a read accepted in the cycle after a write to the same word return the newly written data.
REQ-016 SHALL never issue more than one ack per accepted request, nor an ack without an accepted request.

Reset
REQ-017 SHALL, while rst=1 at a clock edge, set state IDLE, wait counter 0, wb_ack_data=0, wb_stall_data=0, wb_rdata_data=32'h0; memory contents not reset.
REQ-018 SHALL, on rst mid-transaction (WAIT or ACK), drop the transaction with no ack after reset; committed writes persist.

Verification
REQ-019 WAIT_CYCLES=0: write 32'hDEADBEEF sel 4'b1111 addr 0x10, read addr 0x10 next cycle -> ack each following cycle, read data 32'hDEADBEEF, stall never high.
REQ-020 Byte lanes: word 0x10 = 32'hDEADBEEF, write 32'h00AA0000 sel 4'b0100 addr 0x12 -> subsequent read of 0x10 returns 32'hDEAABEEF.
REQ-021 WAIT_CYCLES=3: read accepted at edge N -> stall high cycles N+1..N+3, ack in cycle N+4 only; strobe held during stall not accepted until N+4.
REQ-022 Out of range (DEPTH_WORDS=1024): write 32'h12345678 addr 0x1000 then read 0x1000 -> both acked, read 32'h0; word 0 unchanged.
REQ-023 Abort: WAIT_CYCLES=2, read accepted, cyc dropped in first WAIT cycle -> no ack, state IDLE, next request accepted normally; repeat with rst=1 in WAIT -> outputs 0, no ack.

Source files
------------

// File: rtl/wb_data_ram.sv
// Wishbone-style data RAM with byte-lane writes, a configurable wait-state
// count between request acceptance and ack, and out-of-range suppression.
module wb_data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_bus_cyc_data,
    input  logic        wb_stb_data,
    input  logic        wb_w_r_en_data,
    input  logic [31:0] wb_addr_data,
    input  logic [31:0] wb_wdata_data,
    input  logic [3:0]  wb_sel_data,
    output logic        wb_ack_data,
    output logic        wb_stall_data,
    output logic [31:0] wb_rdata_data
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_cnt;
    logic [3:0]     w_next_cnt;
    logic [31:0]    r_mem [DEPTH_WORDS];
    logic [31:0]    r_hold;
    logic [31:0]    r_rdata;
    logic           w_accept;
    logic           w_in_range;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_word;

    assign wb_stall_data = (r_state == S_WAIT);
    assign wb_ack_data   = (r_state == S_ACK);
    assign wb_rdata_data = r_rdata;

    assign w_accept   = wb_bus_cyc_data && wb_stb_data && !wb_stall_data;
    assign w_in_range = (wb_addr_data >> (AW + 2)) == 32'd0;
    assign w_idx      = wb_addr_data[AW+1:2];
    // Writes report zero data; out-of-range reads also return zero.
    assign w_word     = (!wb_w_r_en_data && w_in_range) ? r_mem[w_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE, S_ACK: begin
                w_next_state = S_IDLE;
                if (w_accept) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = CNT_LOAD;
                    end else begin
                        w_next_state = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (!wb_bus_cyc_data) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = S_ACK;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept && wb_w_r_en_data && w_in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wb_sel_data[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wb_wdata_data[8*b +: 8];
                end
            end
        end
    end

    // Output data only changes on entry to ACK, so it holds between acks and
    // an aborted transaction leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_hold <= w_word;
            end
            if (w_next_state == S_ACK) begin
                r_rdata <= (r_state == S_WAIT) ? r_hold : w_word;
            end
        end
    end

endmodule

// File: tb/tb_wb_data_ram.sv
// Randomized self-checking bench for wb_data_ram: three instances with
// WAIT_CYCLES 0, 3 and 2, checked against a word-array reference model.
module tb_wb_data_ram;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  sel   [3];
    logic        ack   [3];
    logic        stall [3];
    logic [31:0] rdata [3];

    logic [31:0] mem_m   [3][1024];
    logic [31:0] last_rd [3];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    wb_data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[0]), .wb_bus_cyc_data(cyc[0]), .wb_stb_data(stb[0]),
        .wb_w_r_en_data(we[0]), .wb_addr_data(addr[0]), .wb_wdata_data(wdata[0]),
        .wb_sel_data(sel[0]), .wb_ack_data(ack[0]), .wb_stall_data(stall[0]),
        .wb_rdata_data(rdata[0])
    );
    wb_data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]), .wb_bus_cyc_data(cyc[1]), .wb_stb_data(stb[1]),
        .wb_w_r_en_data(we[1]), .wb_addr_data(addr[1]), .wb_wdata_data(wdata[1]),
        .wb_sel_data(sel[1]), .wb_ack_data(ack[1]), .wb_stall_data(stall[1]),
        .wb_rdata_data(rdata[1])
    );
    wb_data_ram #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst[2]), .wb_bus_cyc_data(cyc[2]), .wb_stb_data(stb[2]),
        .wb_w_r_en_data(we[2]), .wb_addr_data(addr[2]), .wb_wdata_data(wdata[2]),
        .wb_sel_data(sel[2]), .wb_ack_data(ack[2]), .wb_stall_data(stall[2]),
        .wb_rdata_data(rdata[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    // Reference: a 1024-word array; returns the data an ack would carry.
    function automatic logic [31:0] model_access(input int k, input logic w,
                                                 input logic [31:0] a, input logic [31:0] d,
                                                 input logic [3:0] s);
        int unsigned idx;
        if (a >= 32'h1000) return 32'h0;
        idx = a / 4;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
            return 32'h0;
        end
        return mem_m[k][idx];
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
        else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        return a;
    endfunction

    // Single transaction from idle, called just after a rising edge.
    task automatic txn(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        logic [31:0] e;
        int wc;
        wc = wait_of(k);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; sel[k] = s;
        @(negedge clk);
        chk("txn_stall_at_req", 32'(stall[k]), 32'h0);
        e = model_access(k, w, a, d, s);
        @(posedge clk); #1;
        stb[k] = 1'b0;
        for (int i = 1; i <= wc + 1; i++) begin
            @(negedge clk);
            chk("txn_stall", 32'(stall[k]), 32'(i <= wc));
            chk("txn_ack", 32'(ack[k]), 32'(i == wc + 1));
            if (i == wc + 1) chk("txn_rdata", rdata[k], e);
            @(posedge clk); #1;
        end
        last_rd[k] = e;
    endtask

    task automatic random_stream_w0(input int n);
        logic        pacc, c, s, w;
        logic [31:0] erd, a, d;
        logic [3:0]  sl;
        pacc = 1'b0;
        erd  = last_rd[0];
        for (int i = 0; i < n; i++) begin
            c = ($urandom_range(0, 7) != 0);
            s = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            a = rand_addr();
            d = $urandom;
            sl = 4'($urandom_range(0, 15));
            cyc[0] = c; stb[0] = s; we[0] = w; addr[0] = a; wdata[0] = d; sel[0] = sl;
            @(negedge clk);
            chk("rnd_ack", 32'(ack[0]), 32'(pacc));
            chk("rnd_rdata", rdata[0], erd);
            chk("rnd_stall", 32'(stall[0]), 32'h0);
            pacc = c && s;
            if (pacc) erd = model_access(0, w, a, d, sl);
            @(posedge clk); #1;
        end
        cyc[0] = 1'b1; stb[0] = 1'b0;
        @(negedge clk);
        chk("rnd_ack_tail", 32'(ack[0]), 32'(pacc));
        chk("rnd_rdata_tail", rdata[0], erd);
        @(posedge clk); #1;
        last_rd[0] = erd;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            addr[k] = '0; wdata[k] = '0; sel[k] = '0; last_rd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'h0);
            chk("reset_stall", 32'(stall[k]), 32'h0);
            chk("reset_rdata", rdata[k], 32'h0);
        end
        @(posedge clk); #1;

        // Prefill the words the random phases touch.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 16; w++) txn(k, 1'b1, 32'(w * 4), $urandom, 4'hF);

        // ---- WAIT_CYCLES = 0: back-to-back write then read ----
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10;
        wdata[0] = 32'hDEADBEEF; sel[0] = 4'hF;
        @(negedge clk);
        e = model_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        @(posedge clk); #1;
        we[0] = 1'b0;
        @(negedge clk);
        chk("b2b_wr_ack", 32'(ack[0]), 32'h1);
        chk("b2b_wr_rdata", rdata[0], 32'h0);
        chk("b2b_stall", 32'(stall[0]), 32'h0);
        e = model_access(0, 1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        stb[0] = 1'b0;
        @(negedge clk);
        chk("b2b_rd_ack", 32'(ack[0]), 32'h1);
        chk("b2b_rd_rdata", rdata[0], 32'hDEADBEEF);
        chk("b2b_stall2", 32'(stall[0]), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_no_extra_ack", 32'(ack[0]), 32'h0);
        chk("b2b_rdata_held", rdata[0], 32'hDEADBEEF);
        @(posedge clk); #1;

        // Byte lane, empty select, out of range.
        txn(0, 1'b1, 32'h12, 32'h00AA0000, 4'b0100);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("byte_lane", last_rd[0], 32'hDEAABEEF);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF);
        chk("sel_zero_nowrite", rdata[0], 32'hDEAABEEF);
        txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF);
        txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        chk("oor_read_zero", rdata[0], 32'h0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF);
        chk("oor_word0_kept", rdata[0], 32'h0BADF00D);

        random_stream_w0(400);

        // ---- WAIT_CYCLES = 3: strobe held through the stall ----
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; sel[1] = 4'h0;
        @(negedge clk);
        chk("w3_req_stall", 32'(stall[1]), 32'h0);
        e = model_access(1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clk); #1;
        we[1] = 1'b1; addr[1] = 32'h14; wdata[1] = 32'h5A5A5A5A; sel[1] = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("w3_hold_stall", 32'(stall[1]), 32'(i % 4 != 0));
            chk("w3_hold_ack", 32'(ack[1]), 32'(i % 4 == 0));
            if (i == 4) begin
                chk("w3_hold_rd", rdata[1], e);
                e = model_access(1, 1'b1, 32'h14, 32'h5A5A5A5A, 4'hF);
            end
            if (i == 8) chk("w3_hold_wr_rd", rdata[1], 32'h0);
            @(posedge clk); #1;
            if (i == 4) stb[1] = 1'b0;
        end
        txn(1, 1'b0, 32'h14, 32'h0, 4'hF);
        chk("w3_held_write", rdata[1], 32'h5A5A5A5A);
        for (int i = 0; i < 40; i++)
            txn(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));

        // ---- WAIT_CYCLES = 2: abort by cyc drop, then by reset ----
        txn(2, 1'b1, 32'h10, 32'hCAFE0001, 4'hF);
        txn(2, 1'b0, 32'h10, 32'h0, 4'hF);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        chk("abort_wait_stall", 32'(stall[2]), 32'h1);
        chk("abort_wait_ack", 32'(ack[2]), 32'h0);
        @(posedge clk); #1;
        cyc[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(ack[2]), 32'h0);
            chk("abort_idle_stall", 32'(stall[2]), 32'h0);
            chk("abort_rdata_held", rdata[2], 32'hCAFE0001);
            @(posedge clk); #1;
        end
        txn(2, 1'b0, 32'h10, 32'h0, 4'hF);
        txn(2, 1'b1, 32'h20, 32'h11223344, 4'hF);
        stb[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        stb[2] = 1'b0; rst[2] = 1'b1;
        @(negedge clk);
        chk("rst_wait_stall", 32'(stall[2]), 32'h1);
        @(posedge clk); #1;
        rst[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_abort_ack", 32'(ack[2]), 32'h0);
            chk("rst_abort_stall", 32'(stall[2]), 32'h0);
            chk("rst_abort_rdata", rdata[2], 32'h0);
            @(posedge clk); #1;
        end
        txn(2, 1'b0, 32'h20, 32'h0, 4'hF);
        chk("rst_write_persists", rdata[2], 32'h11223344);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
